imif_burst_responder: RTL

Responder (slave) end of the cache/memory request interface driven by the D-cache and I-cache: accepts single and burst read/write transactions, serves them from an internal 64-bit-wide SRAM, and signals per-beat and end-of-transaction handshakes. It is used as the on-chip memory behind the caches in standalone NPC builds and as the reference responder in cache testbenches.

---
 rtl/imif_burst_responder_if.sv | 35 +++
 rtl/imif_burst_responder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/imif_burst_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : imif_burst_responder_if
// Brief    : Cache/memory request bus between an initiator (cache) and a
//            burst responder.
// Revision : 1.0 - initial release
// ============================================================================
interface imif_burst_responder_if;
    logic        rw_valid;
    logic        rw_req;
    logic [31:0] rw_addr;
    logic [2:0]  rw_size;
    logic [7:0]  rw_len;
    logic [7:0]  w_strb;
    logic [63:0] rw_w_data;
    logic        w_last;
    logic        rw_ready;
    logic [63:0] data_read;
    logic        r_hs;
    logic        r_last;
    logic        w_hs;
    logic        axi_write_ahead;
    logic        proto_err;

    modport master (
        output rw_valid, rw_req, rw_addr, rw_size, rw_len, w_strb, rw_w_data, w_last,
        input  rw_ready, data_read, r_hs, r_last, w_hs, axi_write_ahead, proto_err
    );

    modport slave (
        input  rw_valid, rw_req, rw_addr, rw_size, rw_len, w_strb, rw_w_data, w_last,
        output rw_ready, data_read, r_hs, r_last, w_hs, axi_write_ahead, proto_err
    );
endinterface
`default_nettype wire

// File: rtl/imif_burst_responder.sv
`default_nettype none
// ============================================================================
// Module   : imif_burst_responder
// Brief    : Burst read/write responder backed by a 64-bit-wide internal SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module imif_burst_responder #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rrst_n,
    imif_burst_responder_if.slave bus
);
    localparam int unsigned c_AW       = $clog2(MEM_WORDS);
    localparam logic [32:0] c_SPAN     = 33'(MEM_WORDS) << 3;
    localparam logic [15:0] c_LAT_LAST = 16'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ADDR   = 3'd1;
    localparam logic [2:0] c_R_WAIT = 3'd2;
    localparam logic [2:0] c_R_BEAT = 3'd3;
    localparam logic [2:0] c_W_BEAT = 3'd4;
    localparam logic [2:0] c_RESP   = 3'd5;
    localparam logic [2:0] c_GAP    = 3'd6;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic            r_req;
    logic            r_oor;
    logic            r_proto_err;
    logic [31:0]     r_addr;
    logic [2:0]      r_size;
    logic [7:0]      r_len;
    logic [7:0]      r_beat;
    logic [15:0]     r_lat;
    logic [63:0]     r_data_read;
    logic [63:0]     r_mem [MEM_WORDS];

    logic            w_last_beat;
    logic            w_in_range;
    logic            w_wr_en;
    logic            w_w_last_bad;
    logic [31:0]     w_inc;
    logic [31:0]     w_rd_addr;
    logic [c_AW-1:0] w_rd_idx;
    logic [c_AW-1:0] w_wr_idx;

    assign w_last_beat  = (r_beat == r_len);
    assign w_in_range   = ({1'b0, bus.rw_addr - BASE_ADDR} < c_SPAN);
    assign w_inc        = 32'd1 << r_size;
    // The read port looks one beat ahead so data_read is registered in the r_hs cycle.
    assign w_rd_addr    = (r_state == c_R_BEAT) ? r_addr + w_inc : r_addr;
    assign w_rd_idx     = c_AW'((w_rd_addr - BASE_ADDR) >> 3);
    assign w_wr_idx     = c_AW'((r_addr - BASE_ADDR) >> 3);
    assign w_wr_en      = (r_state == c_W_BEAT) && !r_oor;
    assign w_w_last_bad = (r_state == c_W_BEAT) && (bus.w_last != w_last_beat);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (bus.rw_valid) w_next = c_ADDR;
            c_ADDR:   w_next = r_req ? c_W_BEAT : ((RD_LAT > 1) ? c_R_WAIT : c_R_BEAT);
            c_R_WAIT: if (r_lat == c_LAT_LAST) w_next = c_R_BEAT;
            c_R_BEAT: if (w_last_beat) w_next = c_RESP;
            c_W_BEAT: if (w_last_beat) w_next = c_RESP;
            c_RESP:   w_next = c_GAP;
            c_GAP:    w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state     <= c_IDLE;
            r_req       <= 1'b0;
            r_oor       <= 1'b0;
            r_addr      <= '0;
            r_size      <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_lat       <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_IDLE: begin
                    if (bus.rw_valid) begin
                        r_req  <= bus.rw_req;
                        r_oor  <= !w_in_range;
                        r_addr <= bus.rw_addr;
                        r_size <= bus.rw_size;
                        r_len  <= bus.rw_len;
                        r_beat <= '0;
                        r_lat  <= '0;
                        if (bus.rw_len > 8'd7) r_proto_err <= 1'b1;
                    end
                end
                c_R_WAIT: r_lat <= r_lat + 16'd1;
                c_R_BEAT, c_W_BEAT: begin
                    r_addr <= r_addr + w_inc;
                    r_beat <= r_beat + 8'd1;
                end
                default: ;
            endcase
            if (w_w_last_bad) r_proto_err <= 1'b1;
        end
    end

    // Holds the last beat until the next read so rw_ready-time sampling works.
    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_data_read <= '0;
        end else if (w_next == c_R_BEAT) begin
            r_data_read <= r_oor ? 64'd0 : r_mem[w_rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.w_strb[i]) r_mem[w_wr_idx][8*i +: 8] <= bus.rw_w_data[8*i +: 8];
            end
        end
    end

    assign bus.rw_ready        = (r_state == c_RESP);
    assign bus.r_hs            = (r_state == c_R_BEAT);
    assign bus.r_last          = (r_state == c_R_BEAT) && w_last_beat;
    assign bus.w_hs            = (r_state == c_W_BEAT);
    assign bus.axi_write_ahead = (r_state == c_ADDR) && r_req;
    assign bus.proto_err       = r_proto_err;
    assign bus.data_read       = r_data_read;
endmodule
`default_nettype wire
